// File: rtl/tiro_nave_if.sv
// Interface bundling the control, geometry and status signals of the ship's shot.
// The master modport is the game side that drives the ship/target geometry and
// requests; the slave modport is the shot block itself.
interface tiro_nave_if;
    logic       iniciarTiro;
    logic       pausa;
    logic       reiniciarJogo;
    logic [9:0] x_nave;
    logic [9:0] y_nave;
    logic [9:0] largura_nave;
    logic [9:0] x_alvo;
    logic [9:0] y_alvo;
    logic [9:0] largura_alvo;
    logic [9:0] altura_alvo;
    logic       alvo_vivo;
    logic       bateu;
    logic       saiu;
    logic       ativo;
    logic [9:0] x_tiro;
    logic [9:0] y_tiro;
    logic [9:0] largura_tiro;
    logic [9:0] altura_tiro;
    logic [7:0] acertos;

    modport master (
        output iniciarTiro, pausa, reiniciarJogo,
        output x_nave, y_nave, largura_nave,
        output x_alvo, y_alvo, largura_alvo, altura_alvo, alvo_vivo,
        input  bateu, saiu, ativo, x_tiro, y_tiro, largura_tiro, altura_tiro, acertos
    );

    modport slave (
        input  iniciarTiro, pausa, reiniciarJogo,
        input  x_nave, y_nave, largura_nave,
        input  x_alvo, y_alvo, largura_alvo, altura_alvo, alvo_vivo,
        output bateu, saiu, ativo, x_tiro, y_tiro, largura_tiro, altura_tiro, acertos
    );
endinterface

// File: rtl/tiro_nave.sv
// tiro_nave: a single shot fired upward from the ship. It moves PASSO pixels
// every DIV_MOV clocks, tests collision against the target box on each move,
// and reports a hit (bateu) or leaving the screen top (saiu).
// Optional feature: define TIRO_CONTADOR_EN to get a saturating 8-bit hit
// counter on acertos; without it acertos is tied to zero.
module tiro_nave #(
    parameter int LARGURA_TIRO = 2,
    parameter int ALTURA_TIRO  = 6,
    parameter int PASSO        = 4,
    parameter int DIV_MOV      = 416666
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    tiro_nave_if.slave  bus
);

    localparam int               CNT_W   = $clog2(DIV_MOV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_MOV - 1);
    localparam logic [10:0]      LARG11  = 11'(LARGURA_TIRO);
    localparam logic [10:0]      ALT11   = 11'(ALTURA_TIRO);
    localparam logic [9:0]       ALT10   = 10'(ALTURA_TIRO);
    localparam logic [9:0]       PASSO10 = 10'(PASSO);

    typedef enum logic [1:0] {
        OCIOSO,
        VOO,
        ACERTO
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             saiu_q, saiu_d;

    logic [9:0]  x_lanc;
    logic [9:0]  y_lanc;
    logic [9:0]  y_mov;
    logic [10:0] xs, ys, xa, ya, xa_fim, ya_fim;
    logic        colide;

    // Launch position: centred on the ship, just above it, clamped at the top edge.
    assign x_lanc = bus.x_nave + {1'b0, bus.largura_nave[9:1]};
    assign y_lanc = (bus.y_nave < ALT10) ? 10'd0 : (bus.y_nave - ALT10);

    // Position after one movement step, clamped at the top edge.
    assign y_mov = (y_q < PASSO10) ? 10'd0 : (y_q - PASSO10);

    // Overlap test in 11 bits so the far edges never wrap; uses the moved y.
    assign xs     = {1'b0, x_q};
    assign ys     = {1'b0, y_mov};
    assign xa     = {1'b0, bus.x_alvo};
    assign ya     = {1'b0, bus.y_alvo};
    assign xa_fim = xa + {1'b0, bus.largura_alvo};
    assign ya_fim = ya + {1'b0, bus.altura_alvo};
    assign colide = bus.alvo_vivo
                    && (xs < xa_fim) && (xa < xs + LARG11)
                    && (ys < ya_fim) && (ya < ys + ALT11);

    // Next-state logic: restart wins, pause freezes everything, otherwise run the shot FSM.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        saiu_d   = saiu_q;

        if (bus.reiniciarJogo) begin
            estado_d = OCIOSO;
            cnt_d    = '0;
            x_d      = '0;
            y_d      = '0;
            saiu_d   = 1'b0;
        end else if (!bus.pausa) begin
            saiu_d = 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (bus.iniciarTiro) begin
                        estado_d = VOO;
                        x_d      = x_lanc;
                        y_d      = y_lanc;
                        cnt_d    = '0;
                    end
                end
                VOO: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        y_d   = y_mov;
                        if (colide) begin
                            estado_d = ACERTO;
                        end else if (y_mov == 10'd0) begin
                            estado_d = OCIOSO;
                            saiu_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ACERTO: begin
                    estado_d = OCIOSO;
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    // State and position registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            saiu_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            saiu_q   <= saiu_d;
        end
    end

    // Pulses are held frozen during a pause but masked, so they appear once on resume.
    assign bus.ativo        = (estado_q != OCIOSO);
    assign bus.bateu        = (estado_q == ACERTO) && !bus.pausa;
    assign bus.saiu         = saiu_q && !bus.pausa;
    assign bus.x_tiro       = x_q;
    assign bus.y_tiro       = y_q;
    assign bus.largura_tiro = 10'(LARGURA_TIRO);
    assign bus.altura_tiro  = 10'(ALTURA_TIRO);

`ifdef TIRO_CONTADOR_EN
    logic [7:0] acertos_q, acertos_d;

    // Hit counter: counts each unpaused ACERTO cycle, saturating at 255.
    always_comb begin
        acertos_d = acertos_q;
        if (bus.reiniciarJogo) begin
            acertos_d = 8'd0;
        end else if ((estado_q == ACERTO) && !bus.pausa && (acertos_q != 8'hFF)) begin
            acertos_d = acertos_q + 8'd1;
        end
    end

    // Hit counter register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            acertos_q <= 8'd0;
        end else begin
            acertos_q <= acertos_d;
        end
    end

    assign bus.acertos = acertos_q;
`else
    assign bus.acertos = 8'd0;
`endif

endmodule

// File: doc/tiro_nave.md
TIRO_NAVE -- requirements
Module: tiro_nave

Interface
REQ-001 Parameter LARGURA_TIRO, default 2, shot width in pixels.
REQ-002 Parameter ALTURA_TIRO, default 6, shot height in pixels.
REQ-003 Parameter PASSO, default 4, pixels moved up per movement tick.
REQ-004 Parameter DIV_MOV, default 416666, CLOCK_50 cycles per movement tick; must be at least 2.
REQ-005 Ports SHALL be:
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- iniciarTiro  in  1  fire request from ship, level-sampled
- pausa  in  1  freeze all motion and timing
- reiniciarJogo  in  1  synchronous game restart
- x_nave, y_nave, largura_nave  in  10 each  ship geometry
- x_alvo, y_alvo, largura_alvo, altura_alvo  in  10 each  target box
- alvo_vivo  in  1  target collidable
- bateu  out  1  one-cycle hit pulse
- saiu  out  1  one-cycle pulse when the shot leaves the top of the screen
- ativo  out  1  shot in flight
- x_tiro, y_tiro  out  10 each  shot top-left position
- largura_tiro, altura_tiro  out  10 each  equal to LARGURA_TIRO and ALTURA_TIRO
- acertos  out  8  hit count; see Configuration

Function
REQ-006 The block SHALL use a registered FSM with states OCIOSO, VOO and ACERTO.
REQ-007 OCIOSO: when iniciarTiro=1 and pausa=0 on a clock edge, go to VOO on that edge.
- Load x_tiro = x_nave + (largura_nave>>1).
- Load y_tiro = y_nave - ALTURA_TIRO, saturating at 0.
- Clear the tick counter; ativo=1 from the next cycle.
REQ-008 In VOO, iniciarTiro SHALL be ignored; one shot at a time.
REQ-009 In VOO, the tick counter SHALL count 0..DIV_MOV-1 and wrap. On the wrap cycle:
- If y_tiro < PASSO, set y_tiro = 0.
- Otherwise set y_tiro = y_tiro - PASSO.
REQ-010 On a movement tick, the collision test SHALL use the new y_tiro.
- A hit is alvo_vivo=1 and the rectangles [x_tiro, x_tiro+LARGURA_TIRO) × [y_tiro, y_tiro+ALTURA_TIRO) and the target box overlap.
- All comparisons are 11-bit unsigned, so they do not overflow.
REQ-011 On a hit, go to ACERTO. Otherwise, if the new y_tiro = 0, pulse saiu for one cycle and go to OCIOSO.
REQ-012 A hit and reaching y_tiro = 0 on the same tick SHALL count as a hit only; no saiu pulse.
REQ-013 ACERTO SHALL last exactly one cycle.
- bateu=1 during that cycle.
- Then go to OCIOSO.
REQ-014 ativo SHALL be 1 exactly in VOO and ACERTO.
REQ-015 x_tiro SHALL hold in flight; x_tiro and y_tiro SHALL hold their last values in OCIOSO.
REQ-016 pausa=1 SHALL freeze the tick counter, position and FSM.
- bateu and saiu SHALL stay low while paused.
- Operation resumes exactly where it stopped.
REQ-017 reiniciarJogo=1 SHALL, on the clock edge, apply the reset values of REQ-019 regardless of pausa.
REQ-018 Target geometry SHALL be sampled only on movement ticks; a target change between ticks cannot cause a hit.

Reset
REQ-019 While reset_n=0, all outputs and state SHALL take their reset values asynchronously:
- State OCIOSO, tick counter 0.
- x_tiro=0, y_tiro=0, ativo=0, bateu=0, saiu=0, acertos=0.
REQ-020 Reset during VOO SHALL abort the shot with no bateu or saiu pulse.
- reset_n is released synchronously by the system reset synchronizer.

Configuration
REQ-021 With macro TIRO_CONTADOR_EN defined:
- acertos SHALL increment by 1 in the ACERTO cycle.
- It saturates at 255.
- reiniciarJogo and reset SHALL clear it.
REQ-022 Without TIRO_CONTADOR_EN, acertos SHALL be constant 0 and no counter register SHALL be inferred.

Verification (DIV_MOV=4, PASSO=4, defaults otherwise)
REQ-023 Launch: x_nave=350, y_nave=420, largura_nave=15, one-cycle iniciarTiro -> next cycle ativo=1, x_tiro=357, y_tiro=414; y_tiro=410 after 4 cycles.
REQ-024 Hit: alvo_vivo=1, target box (356,380,20,10), launch as above -> y_tiro reaches 386 on a tick; one bateu cycle follows, then ativo=0; acertos=1 if TIRO_CONTADOR_EN.
REQ-025 Miss: alvo_vivo=0, y_nave=10 -> y_tiro 4, then 0 with saiu pulse; ativo=0, no bateu.
REQ-026 Pause: pausa=1 for 50 cycles mid-flight -> y_tiro, counter and ativo unchanged; after release the next tick arrives on the remaining count.
REQ-027 Busy and abort: iniciarTiro held high through flight -> exactly one shot; reset_n low mid-flight -> immediate OCIOSO, outputs 0, no pulses.
REQ-028 Simultaneous: target at y=0 overlapping the shot reaching y_tiro = 0 -> bateu only, saiu stays 0.
